// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions for the register slice and axil_interconnect.
package axil_pkg;

    typedef logic [1:0] axil_resp_t;

    localparam axil_resp_t RESP_OKAY   = 2'b00;
    localparam axil_resp_t RESP_EXOKAY = 2'b01;
    localparam axil_resp_t RESP_SLVERR = 2'b10;
    localparam axil_resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_skid_buffer.sv
// Generic 2-entry valid/ready slice: registered ready and valid, FIFO order,
// one beat per cycle while the output drains.
module axil_skid_buffer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    logic             main_valid;
    logic             skid_valid;
    logic             ready_q;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;

    logic in_xfer;
    logic out_xfer;
    logic main_valid_next;
    logic skid_valid_next;
    logic main_load_in;
    logic main_load_skid;
    logic skid_load;

    assign in_xfer  = s_valid & ready_q;
    assign out_xfer = main_valid & m_ready;

    // Main refills from skid first so order is kept; skid only fills while main is stalled.
    always_comb begin
        main_valid_next = main_valid;
        skid_valid_next = skid_valid;
        main_load_in    = 1'b0;
        main_load_skid  = 1'b0;
        skid_load       = 1'b0;
        if (!main_valid || out_xfer) begin
            if (skid_valid) begin
                main_load_skid  = 1'b1;
                main_valid_next = 1'b1;
                skid_valid_next = 1'b0;
            end else if (in_xfer) begin
                main_load_in    = 1'b1;
                main_valid_next = 1'b1;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (in_xfer) begin
            skid_load       = 1'b1;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            main_valid <= main_valid_next;
            skid_valid <= skid_valid_next;
            ready_q    <= !skid_valid_next;
        end
    end

    always_ff @(posedge clk) begin
        if (main_load_skid) begin
            main_data <= skid_data;
        end else if (main_load_in) begin
            main_data <= s_data;
        end
        if (skid_load) begin
            skid_data <= s_data;
        end
    end

    assign s_ready = ready_q;
    assign m_valid = main_valid;
    assign m_data  = main_data;

endmodule

// File: rtl/axil_reg_slice.sv
// Per-master AXI-Lite register slice: AW/W/AR always go through skid buffers;
// B/R are buffered only when AXIL_REG_SLICE_RESP_EN is defined, otherwise wired through.
module axil_reg_slice
    import axil_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32
) (
    input  logic                        aclk,
    input  logic                        areset,

    input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                        s_axil_awvalid,
    output logic                        s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                        s_axil_wvalid,
    output logic                        s_axil_wready,
    output logic [1:0]                  s_axil_bresp,
    output logic                        s_axil_bvalid,
    input  logic                        s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                        s_axil_arvalid,
    output logic                        s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                  s_axil_rresp,
    output logic                        s_axil_rvalid,
    input  logic                        s_axil_rready,

    output logic [AXI_ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic                        m_axil_awvalid,
    input  logic                        m_axil_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                        m_axil_wvalid,
    input  logic                        m_axil_wready,
    input  logic [1:0]                  m_axil_bresp,
    input  logic                        m_axil_bvalid,
    output logic                        m_axil_bready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic                        m_axil_arvalid,
    input  logic                        m_axil_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]                  m_axil_rresp,
    input  logic                        m_axil_rvalid,
    output logic                        m_axil_rready
);

    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int unsigned W_WIDTH    = AXI_DATA_WIDTH + STRB_WIDTH;
    localparam int unsigned R_WIDTH    = AXI_DATA_WIDTH + 2;

    axil_skid_buffer #(.WIDTH(AXI_ADDR_WIDTH)) u_aw (
        .clk     (aclk),
        .rst     (areset),
        .s_valid (s_axil_awvalid),
        .s_ready (s_axil_awready),
        .s_data  (s_axil_awaddr),
        .m_valid (m_axil_awvalid),
        .m_ready (m_axil_awready),
        .m_data  (m_axil_awaddr)
    );

    axil_skid_buffer #(.WIDTH(W_WIDTH)) u_w (
        .clk     (aclk),
        .rst     (areset),
        .s_valid (s_axil_wvalid),
        .s_ready (s_axil_wready),
        .s_data  ({s_axil_wdata, s_axil_wstrb}),
        .m_valid (m_axil_wvalid),
        .m_ready (m_axil_wready),
        .m_data  ({m_axil_wdata, m_axil_wstrb})
    );

    axil_skid_buffer #(.WIDTH(AXI_ADDR_WIDTH)) u_ar (
        .clk     (aclk),
        .rst     (areset),
        .s_valid (s_axil_arvalid),
        .s_ready (s_axil_arready),
        .s_data  (s_axil_araddr),
        .m_valid (m_axil_arvalid),
        .m_ready (m_axil_arready),
        .m_data  (m_axil_araddr)
    );

`ifdef AXIL_REG_SLICE_RESP_EN
    axil_resp_t b_resp;

    // Return paths run downstream-to-upstream, so the interconnect side is the skid input.
    axil_skid_buffer #(.WIDTH(2)) u_b (
        .clk     (aclk),
        .rst     (areset),
        .s_valid (m_axil_bvalid),
        .s_ready (m_axil_bready),
        .s_data  (m_axil_bresp),
        .m_valid (s_axil_bvalid),
        .m_ready (s_axil_bready),
        .m_data  (b_resp)
    );

    assign s_axil_bresp = b_resp;

    axil_skid_buffer #(.WIDTH(R_WIDTH)) u_r (
        .clk     (aclk),
        .rst     (areset),
        .s_valid (m_axil_rvalid),
        .s_ready (m_axil_rready),
        .s_data  ({m_axil_rdata, m_axil_rresp}),
        .m_valid (s_axil_rvalid),
        .m_ready (s_axil_rready),
        .m_data  ({s_axil_rdata, s_axil_rresp})
    );
`else
    assign s_axil_bresp  = m_axil_bresp;
    assign s_axil_bvalid = m_axil_bvalid;
    assign m_axil_bready = s_axil_bready;
    assign s_axil_rdata  = m_axil_rdata;
    assign s_axil_rresp  = m_axil_rresp;
    assign s_axil_rvalid = m_axil_rvalid;
    assign m_axil_rready = s_axil_rready;
`endif

endmodule

// File: tb/tb_axil_reg_slice.sv
// Directed checks for axil_reg_slice; expectations follow AXIL_REG_SLICE_RESP_EN.
module tb_axil_reg_slice;

    logic        aclk = 1'b0;
    logic        areset;

    logic [31:0] s_axil_awaddr;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready;
    logic [31:0] s_axil_araddr;
    logic        s_axil_arvalid;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready;

    logic [31:0] m_axil_awaddr;
    logic        m_axil_awvalid;
    logic        m_axil_awready;
    logic [31:0] m_axil_wdata;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_wvalid;
    logic        m_axil_wready;
    logic [1:0]  m_axil_bresp;
    logic        m_axil_bvalid;
    logic        m_axil_bready;
    logic [31:0] m_axil_araddr;
    logic        m_axil_arvalid;
    logic        m_axil_arready;
    logic [31:0] m_axil_rdata;
    logic [1:0]  m_axil_rresp;
    logic        m_axil_rvalid;
    logic        m_axil_rready;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    axil_reg_slice #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .m_axil_awaddr  (m_axil_awaddr),
        .m_axil_awvalid (m_axil_awvalid),
        .m_axil_awready (m_axil_awready),
        .m_axil_wdata   (m_axil_wdata),
        .m_axil_wstrb   (m_axil_wstrb),
        .m_axil_wvalid  (m_axil_wvalid),
        .m_axil_wready  (m_axil_wready),
        .m_axil_bresp   (m_axil_bresp),
        .m_axil_bvalid  (m_axil_bvalid),
        .m_axil_bready  (m_axil_bready),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] exp_addr;
    logic [31:0] snap_addr;
    logic        s_x;
    logic        m_x;
    logic        stalled;
    int unsigned n_out;

    initial begin
        areset = 1'b1;
        s_axil_awaddr = '0; s_axil_awvalid = 1'b0;
        s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
        s_axil_bready = 1'b1;
        s_axil_araddr = '0; s_axil_arvalid = 1'b0;
        s_axil_rready = 1'b1;
        m_axil_awready = 1'b1; m_axil_wready = 1'b1; m_axil_arready = 1'b1;
        m_axil_bresp = '0; m_axil_bvalid = 1'b0;
        m_axil_rdata = '0; m_axil_rresp = '0; m_axil_rvalid = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_awready", s_axil_awready, 0);
        chk("rst_wready",  s_axil_wready, 0);
        chk("rst_arready", s_axil_arready, 0);
        chk("rst_valids",  {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 0);
        areset = 1'b0;
        tick();
        chk("post_rst_readies", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);

        // Single write
        s_axil_awaddr = 32'h1000_0004; s_axil_awvalid = 1'b1;
        s_axil_wdata = 32'hDEAD_BEEF; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
        chk("wr_pre_awvalid", m_axil_awvalid, 0);
        tick();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        chk("wr_awvalid", m_axil_awvalid, 1);
        chk("wr_awaddr",  m_axil_awaddr, 32'h1000_0004);
        chk("wr_wvalid",  m_axil_wvalid, 1);
        chk("wr_wdata",   m_axil_wdata, 32'hDEAD_BEEF);
        chk("wr_wstrb",   m_axil_wstrb, 4'hF);
        tick();
        chk("wr_drained", {m_axil_awvalid, m_axil_wvalid}, 0);
        m_axil_bresp = 2'b00; m_axil_bvalid = 1'b1;
`ifdef AXIL_REG_SLICE_RESP_EN
        #1;
        chk("b_pre_valid", s_axil_bvalid, 0);
        tick();
        m_axil_bvalid = 1'b0;
        chk("b_valid", s_axil_bvalid, 1);
        chk("b_resp",  s_axil_bresp, 2'b00);
        tick();
        chk("b_drained", s_axil_bvalid, 0);
`else
        #1;
        chk("b_valid", s_axil_bvalid, 1);
        chk("b_resp",  s_axil_bresp, 2'b00);
        chk("b_ready", m_axil_bready, 1);
        m_axil_bvalid = 1'b0;
        tick();
`endif

        // Back-to-back reads, downstream always ready
        for (int i = 0; i < 16; i++) begin
            s_axil_araddr = 32'(i * 4); s_axil_arvalid = 1'b1;
            chk("b2b_arready", s_axil_arready, 1);
            tick();
            chk("b2b_arvalid", m_axil_arvalid, 1);
            chk("b2b_araddr",  m_axil_araddr, 64'(i * 4));
        end
        s_axil_arvalid = 1'b0;
        tick();
        chk("b2b_idle", m_axil_arvalid, 0);

        // Stall: three W beats against a blocked downstream
        m_axil_wready = 1'b0;
        s_axil_wvalid = 1'b1; s_axil_wstrb = 4'h1; s_axil_wdata = 32'hA;
        chk("st_rdy1", s_axil_wready, 1);
        tick();
        s_axil_wdata = 32'hB;
        chk("st_rdy2", s_axil_wready, 1);
        tick();
        s_axil_wdata = 32'hC;
        chk("st_rdy3", s_axil_wready, 0);
        tick();
        chk("st_rdy_hold", s_axil_wready, 0);
        chk("st_head",     m_axil_wdata, 32'hA);
        chk("st_valid",    m_axil_wvalid, 1);
        m_axil_wready = 1'b1;
        tick();
        chk("st_second", m_axil_wdata, 32'hB);
        chk("st_rdy_back", s_axil_wready, 1);
        tick();
        s_axil_wvalid = 1'b0;
        chk("st_third", m_axil_wdata, 32'hC);
        chk("st_third_v", m_axil_wvalid, 1);
        tick();
        chk("st_empty", m_axil_wvalid, 0);

        // Random ready/valid on AR with scoreboard and stability checks
        n_out = 0;
        for (int c = 0; c < 600; c++) begin
            s_x = s_axil_arvalid & s_axil_arready;
            m_x = m_axil_arvalid & m_axil_arready;
            stalled = m_axil_arvalid & !m_axil_arready;
            snap_addr = m_axil_araddr;
            if (s_x) exp_q.push_back(s_axil_araddr);
            tick();
            if (m_x) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("rnd_extra_beat", 1, 0);
                end else begin
                    exp_addr = exp_q.pop_front();
                    chk("rnd_order", snap_addr, exp_addr);
                end
            end
            if (stalled) begin
                chk("rnd_hold_v", m_axil_arvalid, 1);
                chk("rnd_hold_d", m_axil_araddr, snap_addr);
            end
            if (!s_axil_arvalid || s_x) begin
                s_axil_arvalid = 1'($urandom_range(1, 0));
                s_axil_araddr  = $urandom;
            end
            m_axil_arready = 1'($urandom_range(1, 0));
        end
        s_axil_arvalid = 1'b0;
        m_axil_arready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (m_axil_arvalid) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_extra_drain", 1, 0);
                end else begin
                    exp_addr = exp_q.pop_front();
                    chk("rnd_drain", m_axil_araddr, exp_addr);
                end
            end
            tick();
        end
        chk("rnd_left", exp_q.size(), 0);
        chk("rnd_some_out", (n_out > 50), 1);

        // Reset with both W registers full
        m_axil_wready = 1'b0;
        s_axil_wvalid = 1'b1; s_axil_wdata = 32'h11;
        tick();
        s_axil_wdata = 32'h22;
        tick();
        s_axil_wvalid = 1'b0;
        chk("mr_full", s_axil_wready, 0);
        areset = 1'b1;
        tick();
        chk("mr_valid", m_axil_wvalid, 0);
        chk("mr_rdy", {s_axil_awready, s_axil_wready, s_axil_arready}, 0);
        areset = 1'b0;
        m_axil_wready = 1'b1;
        tick();
        chk("mr_rdy_back", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
        chk("mr_no_stale", m_axil_wvalid, 0);
        tick();
        chk("mr_no_stale2", m_axil_wvalid, 0);

        // Read response return path
        m_axil_rdata = 32'hCAFE_0001; m_axil_rresp = 2'b10; m_axil_rvalid = 1'b1;
`ifdef AXIL_REG_SLICE_RESP_EN
        #1;
        chk("r_pre_valid", s_axil_rvalid, 0);
        chk("r_mready",    m_axil_rready, 1);
        tick();
        m_axil_rvalid = 1'b0;
        chk("r_valid", s_axil_rvalid, 1);
        chk("r_data",  s_axil_rdata, 32'hCAFE_0001);
        chk("r_resp",  s_axil_rresp, 2'b10);
        tick();
        chk("r_drained", s_axil_rvalid, 0);
`else
        #1;
        chk("r_valid", s_axil_rvalid, 1);
        chk("r_data",  s_axil_rdata, 32'hCAFE_0001);
        chk("r_resp",  s_axil_rresp, 2'b10);
        s_axil_rready = 1'b0; s_axil_bready = 1'b0;
        #1;
        chk("r_rready_lo", m_axil_rready, 0);
        chk("b_bready_lo", m_axil_bready, 0);
        s_axil_rready = 1'b1;
        #1;
        chk("r_rready_hi", m_axil_rready, 1);
        m_axil_rvalid = 1'b0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
